psum_accumulator: RTL and testbench

Channel-wise partial-sum accumulator that sits directly after the 3x3 adder tree in the convolution datapath. It consumes one valid-tagged window sum per cycle and accumulates `CHANNELS` consecutive sums into one output-pixel value. It buffers finished pixels in a small FIFO and hands them to the output writer over a valid/ready handshake. The adder tree has no backpressure, so overflow is detected and flagged rather than stalled.

---
 rtl/psum_accumulator.sv | 118 +++++++++++
 tb/tb_psum_accumulator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates CHANNELS consecutive window sums from the adder
// tree into one output-pixel value and queues finished pixels in a small FIFO
// drained over a valid/ready handshake. The adder tree cannot be stalled, so a
// pixel finishing while the FIFO is full is dropped and flagged in a sticky bit.
//
// Handshake: dout/dout_valid come from registered FIFO state only. A pop happens
// on a rising edge where dout_valid && dout_ready. While dout_valid is high,
// dout holds the oldest entry until it is popped. dout_valid does not depend on
// dout_ready, and dout reads 0 whenever dout_valid is low.
module psum_accumulator #(
  parameter int WIDTH      = 32,
  parameter int CHANNELS   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adder_valid,
  input  logic [WIDTH-1:0]              din,
  input  logic                          clear,
  output logic                          dout_valid,
  output logic [WIDTH-1:0]              dout,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [CW-1:0]   CH_LAST = CW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] FULL    = CNTW'(FIFO_DEPTH);

  logic [CW-1:0]    ch_cnt_q, ch_cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic             accept;
  logic             last_ch;
  logic [WIDTH-1:0] sum;
  logic             push_req;
  logic             push_ok;
  logic             pop;

  // Channel 0 starts a fresh pixel; later channels add modulo 2^WIDTH.
  always_comb begin
    accept   = adder_valid && !clear;
    last_ch  = (ch_cnt_q == CH_LAST);
    sum      = (ch_cnt_q == '0) ? din : acc_q + din;
    push_req = accept && last_ch;
    pop      = dout_valid && dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok  = push_req && ((count_q != FULL) || pop);
  end

  // Next-state for the channel counter and accumulator; clear wins over data.
  always_comb begin
    ch_cnt_d = ch_cnt_q;
    acc_d    = acc_q;
    if (clear) begin
      ch_cnt_d = '0;
      acc_d    = '0;
    end else if (accept) begin
      acc_d    = sum;
      ch_cnt_d = last_ch ? '0 : ch_cnt_q + CW'(1);
    end
  end

  // Next-state for FIFO pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) wr_d = wr_q + PW'(1);
    if (pop)     rd_d = rd_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cnt_q <= '0;
      acc_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ch_cnt_q <= ch_cnt_d;
      acc_q    <= acc_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= sum;
  end

  assign dout_valid = (count_q != '0);
  assign dout       = dout_valid ? mem_q[rd_q] : '0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator (WIDTH=32, CHANNELS=3, FIFO_DEPTH=4).
module tb_psum_accumulator;

  logic        clk;
  logic        rst;
  logic        adder_valid;
  logic [31:0] din;
  logic        clear;
  logic        dout_valid;
  logic [31:0] dout;
  logic        dout_ready;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_checks;
  int n_pass;

  typedef struct {
    logic        av;
    logic [31:0] din;
    logic        clr;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  ec;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  psum_accumulator #(.WIDTH(32), .CHANNELS(3), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .adder_valid(adder_valid),
    .din        (din),
    .clear      (clear),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_ready (dout_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [31:0] ed,
                           input logic [2:0] ec, input logic eo);
    check({tag, ".dout_valid"}, {31'd0, dout_valid}, {31'd0, ev});
    check({tag, ".dout"}, dout, ed);
    check({tag, ".fifo_count"}, {29'd0, fifo_count}, {29'd0, ec});
    check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  // driver: apply inputs at negedge, sample 1 time unit after the next posedge
  task automatic drive(input logic av, input logic [31:0] d, input logic clr, input logic rdy);
    @(negedge clk);
    adder_valid = av;
    din         = d;
    clear       = clr;
    dout_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic av, input logic [31:0] d, input logic clr,
                              input logic rdy, input logic ev, input logic [31:0] ed,
                              input logic [2:0] ec, input logic eo);
    vec_t v;
    v.av = av; v.din = d; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
    vecs.push_back(v);
  endfunction

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b0;
    adder_valid = 1'b0;
    din         = '0;
    clear       = 1'b0;
    dout_ready  = 1'b0;

    // Basic: 5+7+11 = 23, visible exactly one cycle after the third input
    add(1, 5, 0, 1, 0, 0, 0, 0);
    add(1, 7, 0, 1, 0, 0, 0, 0);
    add(1, 11, 0, 1, 1, 23, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Gaps and order: 1,_,2,_,_,3 -> 6 then 10,20,30 -> 60
    add(1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 2, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 3, 0, 1, 1, 6, 1, 0);
    add(1, 10, 0, 1, 0, 0, 0, 0);
    add(1, 20, 0, 1, 0, 0, 0, 0);
    add(1, 30, 0, 1, 1, 60, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Wrap-around modulo 2^32
    add(1, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0);
    add(1, 2, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Clear mid-pixel, coincident valid ignored
    add(1, 9, 0, 1, 0, 0, 0, 0);
    add(1, 100, 1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Backpressure: five pixels k,0,0 with ready low; the fifth is dropped
    for (int k = 1; k <= 5; k++) begin
      logic [2:0] pre;
      logic [2:0] post;
      pre  = (k - 1 > 4) ? 3'd4 : 3'(k - 1);
      post = (k > 4) ? 3'd4 : 3'(k);
      add(1, 32'(k), 0, 0, (pre != 0), (pre != 0) ? 32'd1 : 32'd0, pre, 0);
      add(1, 0, 0, 0, (pre != 0), (pre != 0) ? 32'd1 : 32'd0, pre, 0);
      add(1, 0, 0, 0, 1, 1, post, (k == 5));
    end
    // Drain 1..4; overflow stays set
    add(0, 0, 0, 1, 1, 2, 3, 1);
    add(0, 0, 0, 1, 1, 3, 2, 1);
    add(0, 0, 0, 1, 1, 4, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);

    // reset state
    #12;
    check_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].din, vecs[i].clr, vecs[i].rdy);
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].eo);
    end

    // Reset mid-pixel with a result queued and overflow set
    drive(1, 7, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    check_all("rst_pre", 1, 7, 1, 1);
    drive(1, 4, 0, 0);
    drive(1, 4, 0, 0);
    @(negedge clk);
    adder_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_all("rst_mid", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 0, 1);
    drive(1, 2, 0, 1);
    drive(1, 3, 0, 1);
    check_all("rst_after", 1, 6, 1, 0);
    drive(0, 0, 0, 1);
    check_all("rst_drain", 0, 0, 0, 0);

    // Full plus pop: fill 1..4, then pixel 5 completes while popping
    for (int k = 1; k <= 4; k++) begin
      drive(1, 32'(k), 0, 0);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
    end
    check_all("full", 1, 1, 4, 0);
    drive(1, 5, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 1);
    check_all("full_pop", 1, 2, 4, 0);
    for (int k = 3; k <= 5; k++) begin
      drive(0, 0, 0, 1);
      check_all($sformatf("fp_drain%0d", k), 1, 32'(k), 3'(6 - k), 0);
    end
    drive(0, 0, 0, 1);
    check_all("fp_empty", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
